// File: rtl/clock_mode_ctrl.sv
// clock_mode_ctrl: time-keeping and mode sequencer for the digital clock.
// Keeps hh:mm:ss in BCD, debounces the mode/inc buttons on the 100 Hz
// timebase, and steps RUN -> SET_HOUR -> SET_MIN -> RUN on mode presses.
// Optional hourly chime is compiled in with the macro HOURLY_CHIME_EN;
// without it the chime port is tied low.
module clock_mode_ctrl #(
    parameter int DB_SAMPLES = 3,
    parameter int INIT_HOUR  = 12,
    parameter int INIT_MIN   = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       f1Hz,
    input  logic       f100Hz,
    input  logic       key_mode_n,
    input  logic       key_inc_n,
    output logic [1:0] hour_t,
    output logic [3:0] hour_u,
    output logic [2:0] min_t,
    output logic [3:0] min_u,
    output logic [2:0] sec_t,
    output logic [3:0] sec_u,
    output logic [2:0] blink,
    output logic [1:0] mode,
    output logic       chime
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2
    } mode_e;

    localparam logic [1:0] INIT_HT = 2'(INIT_HOUR / 10);
    localparam logic [3:0] INIT_HU = 4'(INIT_HOUR % 10);
    localparam logic [2:0] INIT_MT = 3'(INIT_MIN / 10);
    localparam logic [3:0] INIT_MU = 4'(INIT_MIN % 10);
    localparam logic [3:0] DB_LAST = 4'(DB_SAMPLES - 1);

    // Minute/second style increment, 59 wraps to 00.
    function automatic logic [6:0] inc_sexa(input logic [2:0] t, input logic [3:0] u);
        if (u == 4'd9) begin
            if (t == 3'd5) return 7'd0;
            return {t + 3'd1, 4'd0};
        end
        return {t, u + 4'd1};
    endfunction

    // Hour increment, 23 wraps to 00.
    function automatic logic [5:0] inc_hour(input logic [1:0] t, input logic [3:0] u);
        if (t == 2'd2 && u == 4'd3) return 6'd0;
        if (u == 4'd9) return {t + 2'd1, 4'd0};
        return {t, u + 4'd1};
    endfunction

    logic f1_s, f1_d, f100_s, f100_d;
    logic tick_1hz, tick_100hz;

    // Register the timebase square waves once and keep a delayed copy for edge detect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f1_s   <= 1'b0;
            f1_d   <= 1'b0;
            f100_s <= 1'b0;
            f100_d <= 1'b0;
        end else begin
            f1_s   <= f1Hz;
            f1_d   <= f1_s;
            f100_s <= f100Hz;
            f100_d <= f100_s;
        end
    end

    assign tick_1hz   = f1_s & ~f1_d;
    assign tick_100hz = f100_s & ~f100_d;

    // Key index 0 = mode, 1 = inc. All levels are active-low.
    logic [1:0] keys, sync1, sync2, acc, acc_d, armed, press;
    logic [3:0] dcnt [2];
    logic [3:0] rcnt [2];

    assign keys = {key_inc_n, key_mode_n};

    // Synchronise, sample at 100 Hz, accept a new level after DB_SAMPLES equal samples;
    // a key is only armed once a released level has been confirmed since reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 2'b11;
            sync2 <= 2'b11;
            acc   <= 2'b11;
            acc_d <= 2'b11;
            armed <= 2'b00;
            for (int k = 0; k < 2; k++) begin
                dcnt[k] <= '0;
                rcnt[k] <= '0;
            end
        end else begin
            sync1 <= keys;
            sync2 <= sync1;
            acc_d <= acc;
            if (tick_100hz) begin
                for (int k = 0; k < 2; k++) begin
                    if (sync2[k] != acc[k]) begin
                        if (dcnt[k] == DB_LAST) begin
                            acc[k]  <= sync2[k];
                            dcnt[k] <= '0;
                        end else begin
                            dcnt[k] <= dcnt[k] + 4'd1;
                        end
                    end else begin
                        dcnt[k] <= '0;
                    end
                    if (!armed[k]) begin
                        if (!sync2[k])             rcnt[k]  <= '0;
                        else if (rcnt[k] == DB_LAST) armed[k] <= 1'b1;
                        else                       rcnt[k]  <= rcnt[k] + 4'd1;
                    end
                end
            end
        end
    end

    assign press = acc_d & ~acc & armed;

    mode_e      state, state_nx;
    logic [1:0] ht, ht_nx;
    logic [3:0] hu, hu_nx, mu, mu_nx, su, su_nx;
    logic [2:0] mt, mt_nx, st, st_nx;
    logic [2:0] blink_q, blink_nx;

    // State, time digits and blink mask registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= RUN;
            ht      <= INIT_HT;
            hu      <= INIT_HU;
            mt      <= INIT_MT;
            mu      <= INIT_MU;
            st      <= 3'd0;
            su      <= 4'd0;
            blink_q <= 3'b000;
        end else begin
            state   <= state_nx;
            ht      <= ht_nx;
            hu      <= hu_nx;
            mt      <= mt_nx;
            mu      <= mu_nx;
            st      <= st_nx;
            su      <= su_nx;
            blink_q <= blink_nx;
        end
    end

    // Next state and time: mode press wins over both the 1 Hz tick and inc press.
    always_comb begin
        state_nx = state;
        ht_nx    = ht;
        hu_nx    = hu;
        mt_nx    = mt;
        mu_nx    = mu;
        st_nx    = st;
        su_nx    = su;
        blink_nx = 3'b000;
        case (state)
            RUN: begin
                if (press[0]) begin
                    state_nx = SET_HOUR;
                end else if (tick_1hz) begin
                    {st_nx, su_nx} = inc_sexa(st, su);
                    if (st == 3'd5 && su == 4'd9) begin
                        {mt_nx, mu_nx} = inc_sexa(mt, mu);
                        if (mt == 3'd5 && mu == 4'd9) {ht_nx, hu_nx} = inc_hour(ht, hu);
                    end
                end
            end
            SET_HOUR: begin
                if (press[0])      state_nx = SET_MIN;
                else if (press[1]) {ht_nx, hu_nx} = inc_hour(ht, hu);
            end
            SET_MIN: begin
                if (press[0]) begin
                    state_nx = RUN;
                    st_nx    = 3'd0;
                    su_nx    = 4'd0;
                end else if (press[1]) begin
                    {mt_nx, mu_nx} = inc_sexa(mt, mu);
                end
            end
            default: state_nx = RUN;
        endcase
        if (state_nx == SET_HOUR)     blink_nx = {f1_s, 2'b00};
        else if (state_nx == SET_MIN) blink_nx = {1'b0, f1_s, 1'b0};
    end

`ifdef HOURLY_CHIME_EN
    logic chime_q, chime_nx;

    assign chime_nx = (state_nx == RUN) && (mt_nx == 3'd0) && (mu_nx == 4'd0)
                      && (st_nx == 3'd0) && (su_nx < 4'd5);

    // Chime register, aligned with the digits it is derived from.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) chime_q <= 1'b0;
        else        chime_q <= chime_nx;
    end

    assign chime = chime_q;
`else
    assign chime = 1'b0;
`endif

    assign hour_t = ht;
    assign hour_u = hu;
    assign min_t  = mt;
    assign min_u  = mu;
    assign sec_t  = st;
    assign sec_u  = su;
    assign blink  = blink_q;
    assign mode   = state;

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Testbench for clock_mode_ctrl: drives f1Hz/f100Hz/keys and compares all
// outputs against an integer hh:mm:ss + mode reference model.
module tb_clock_mode_ctrl;

  localparam int DB_SAMPLES = 3;
  localparam int INIT_HOUR  = 12;
  localparam int INIT_MIN   = 0;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       f1Hz = 1'b0;
  logic       f100Hz = 1'b0;
  logic       key_mode_n = 1'b1;
  logic       key_inc_n = 1'b1;
  logic [1:0] hour_t;
  logic [3:0] hour_u;
  logic [2:0] min_t;
  logic [3:0] min_u;
  logic [2:0] sec_t;
  logic [3:0] sec_u;
  logic [2:0] blink;
  logic [1:0] mode;
  logic       chime;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  int m_h, m_m, m_s, m_mode;

  logic [25:0] obs;
  assign obs = {hour_t, hour_u, min_t, min_u, sec_t, sec_u, mode, blink, chime};

  clock_mode_ctrl #(
    .DB_SAMPLES(DB_SAMPLES),
    .INIT_HOUR(INIT_HOUR),
    .INIT_MIN(INIT_MIN)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .f1Hz(f1Hz),
    .f100Hz(f100Hz),
    .key_mode_n(key_mode_n),
    .key_inc_n(key_inc_n),
    .hour_t(hour_t),
    .hour_u(hour_u),
    .min_t(min_t),
    .min_u(min_u),
    .sec_t(sec_t),
    .sec_u(sec_u),
    .blink(blink),
    .mode(mode),
    .chime(chime)
  );

  // clock / timebase
  initial forever #5 clk = ~clk;

  initial begin
    forever begin
      repeat (5) @(negedge clk);
      f100Hz = ~f100Hz;
    end
  end

  // ---------------- reference model ----------------
  function automatic void model_reset();
    m_h = INIT_HOUR; m_m = INIT_MIN; m_s = 0; m_mode = 0;
  endfunction

  function automatic void model_tick();
    int t;
    if (m_mode == 0) begin
      t = (m_h * 3600 + m_m * 60 + m_s + 1) % 86400;
      m_h = t / 3600; m_m = (t / 60) % 60; m_s = t % 60;
    end
  endfunction

  function automatic void model_mode();
    if (m_mode == 0) m_mode = 1;
    else if (m_mode == 1) m_mode = 2;
    else begin m_mode = 0; m_s = 0; end
  endfunction

  function automatic void model_inc();
    if (m_mode == 1) m_h = (m_h + 1) % 24;
    else if (m_mode == 2) m_m = (m_m + 1) % 60;
  endfunction

  function automatic logic [25:0] exp_vec();
    logic [2:0] b;
    logic c;
    b = 3'b000;
    if (m_mode == 1) b = {f1Hz, 2'b00};
    else if (m_mode == 2) b = {1'b0, f1Hz, 1'b0};
    c = 1'b0;
`ifdef HOURLY_CHIME_EN
    c = (m_mode == 0 && m_m == 0 && m_s < 5);
`endif
    return {2'(m_h / 10), 4'(m_h % 10), 3'(m_m / 10), 4'(m_m % 10),
            3'(m_s / 10), 4'(m_s % 10), 2'(m_mode), b, c};
  endfunction

  // ---------------- driver tasks ----------------
  // Key held low for 4 samples then released for 4 samples.
  task automatic press(input bit which);
    @(negedge f100Hz);
    if (which) key_inc_n = 1'b0; else key_mode_n = 1'b0;
    repeat (40) @(negedge clk);
    key_inc_n = 1'b1;
    key_mode_n = 1'b1;
    repeat (40) @(negedge clk);
  endtask

  task automatic press_mode();
    press(1'b0);
    model_mode();
  endtask

  task automatic press_inc();
    press(1'b1);
    model_inc();
  endtask

  task automatic tick_sec(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      f1Hz = 1'b1;
      repeat (4) @(negedge clk);
      f1Hz = 1'b0;
      repeat (4) @(negedge clk);
      model_tick();
    end
  endtask

  task automatic set_hm(input int h, input int m);
    press_mode();
    repeat ((h - m_h + 24) % 24) press_inc();
    press_mode();
    repeat ((m - m_m + 60) % 60) press_inc();
    press_mode();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    model_reset();
    repeat (3) @(negedge clk);
    n_vec++;
    if (obs !== exp_vec()) begin n_err++; $display("FAIL reset_state: dut=%h model=%h", obs, exp_vec()); end
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    n_vec++;
    if (obs !== exp_vec()) begin n_err++; $display("FAIL after_release: dut=%h model=%h", obs, exp_vec()); end
    tick_sec(3);
    n_vec++;
    if (obs !== exp_vec()) begin n_err++; $display("FAIL three_ticks: dut=%h model=%h", obs, exp_vec()); end
  endtask

  task automatic test_set_sequence();
    tick_sec(34);
    n_vec++;
    if (obs !== exp_vec()) begin n_err++; $display("FAIL at_12_00_37: dut=%h model=%h", obs, exp_vec()); end
    press_mode();
    f1Hz = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++;
    if (obs !== exp_vec()) begin n_err++; $display("FAIL blink_hour_on: dut=%h model=%h", obs, exp_vec()); end
    f1Hz = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if (obs !== exp_vec()) begin n_err++; $display("FAIL blink_hour_off: dut=%h model=%h", obs, exp_vec()); end
    tick_sec(2);
    repeat (5) press_inc();
    n_vec++;
    if (obs !== exp_vec()) begin n_err++; $display("FAIL hour_inc5: dut=%h model=%h", obs, exp_vec()); end
    press_mode();
    f1Hz = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++;
    if (obs !== exp_vec()) begin n_err++; $display("FAIL blink_min_on: dut=%h model=%h", obs, exp_vec()); end
    f1Hz = 1'b0;
    repeat (3) @(negedge clk);
    repeat (61) press_inc();
    tick_sec(2);
    n_vec++;
    if (obs !== exp_vec()) begin n_err++; $display("FAIL min_inc61: dut=%h model=%h", obs, exp_vec()); end
    press_mode();
    n_vec++;
    if (obs !== exp_vec()) begin n_err++; $display("FAIL set_exit_17_01_00: dut=%h model=%h", obs, exp_vec()); end
  endtask

  task automatic test_collision();
    set_hm(10, 10);
    tick_sec(10);
    n_vec++;
    if (obs !== exp_vec()) begin n_err++; $display("FAIL collision_pre: dut=%h model=%h", obs, exp_vec()); end
    // third accepted sample lands one clk after the f100 rise; raising f1Hz one clk
    // after that rise makes the tick pulse and the press pulse share one edge
    @(negedge f100Hz);
    key_mode_n = 1'b0;
    @(posedge f100Hz);
    @(posedge f100Hz);
    @(posedge f100Hz);
    @(negedge clk);
    f1Hz = 1'b1;
    repeat (4) @(negedge clk);
    f1Hz = 1'b0;
    repeat (4) @(negedge clk);
    model_mode();
    n_vec++;
    if (obs !== exp_vec()) begin n_err++; $display("FAIL collision_mode_vs_tick: dut=%h model=%h", obs, exp_vec()); end
    key_mode_n = 1'b1;
    repeat (40) @(negedge clk);
    press_mode();
    press_mode();
    n_vec++;
    if (obs !== exp_vec()) begin n_err++; $display("FAIL collision_back_to_run: dut=%h model=%h", obs, exp_vec()); end
  endtask

  task automatic test_rollover();
    set_hm(23, 59);
    tick_sec(58);
    n_vec++;
    if (obs !== exp_vec()) begin n_err++; $display("FAIL at_23_59_58: dut=%h model=%h", obs, exp_vec()); end
    tick_sec(1);
    n_vec++;
    if (obs !== exp_vec()) begin n_err++; $display("FAIL at_23_59_59: dut=%h model=%h", obs, exp_vec()); end
    for (int i = 0; i < 6; i++) begin
      tick_sec(1);
      n_vec++;
      if (obs !== exp_vec()) begin n_err++; $display("FAIL rollover_sec%0d: dut=%h model=%h", i, obs, exp_vec()); end
    end
  endtask

  task automatic test_debounce();
    press_mode();
    repeat ((23 - m_h + 24) % 24) press_inc();
    n_vec++;
    if (obs !== exp_vec()) begin n_err++; $display("FAIL db_hour23: dut=%h model=%h", obs, exp_vec()); end
    // two low samples only, then short glitches placed between samples
    @(negedge f100Hz);
    key_inc_n = 1'b0;
    repeat (20) @(negedge clk);
    key_inc_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge f100Hz);
      @(negedge clk);
      key_inc_n = 1'b0;
      @(negedge clk);
      key_inc_n = 1'b1;
    end
    repeat (40) @(negedge clk);
    n_vec++;
    if (obs !== exp_vec()) begin n_err++; $display("FAIL db_short_low: dut=%h model=%h", obs, exp_vec()); end
    // long hold: exactly one increment
    @(negedge f100Hz);
    key_inc_n = 1'b0;
    repeat (100) @(negedge clk);
    model_inc();
    n_vec++;
    if (obs !== exp_vec()) begin n_err++; $display("FAIL db_hold_early: dut=%h model=%h", obs, exp_vec()); end
    repeat (400) @(negedge clk);
    n_vec++;
    if (obs !== exp_vec()) begin n_err++; $display("FAIL db_hold_50: dut=%h model=%h", obs, exp_vec()); end
    key_inc_n = 1'b1;
    repeat (40) @(negedge clk);
    n_vec++;
    if (obs !== exp_vec()) begin n_err++; $display("FAIL db_release: dut=%h model=%h", obs, exp_vec()); end
    press_mode();
    press_mode();
  endtask

  task automatic test_random();
    for (int it = 0; it < 2; it++) begin
      tick_sec($urandom_range(0, 12));
      n_vec++;
      if (obs !== exp_vec()) begin n_err++; $display("FAIL rnd%0d_run: dut=%h model=%h", it, obs, exp_vec()); end
      press_mode();
      tick_sec($urandom_range(1, 3));
      repeat ($urandom_range(0, 26)) press_inc();
      n_vec++;
      if (obs !== exp_vec()) begin n_err++; $display("FAIL rnd%0d_hour: dut=%h model=%h", it, obs, exp_vec()); end
      press_mode();
      repeat ($urandom_range(0, 62)) press_inc();
      n_vec++;
      if (obs !== exp_vec()) begin n_err++; $display("FAIL rnd%0d_min: dut=%h model=%h", it, obs, exp_vec()); end
      press_mode();
      n_vec++;
      if (obs !== exp_vec()) begin n_err++; $display("FAIL rnd%0d_exit: dut=%h model=%h", it, obs, exp_vec()); end
    end
  endtask

  task automatic test_async_reset();
    press_mode();
    press_mode();
    n_vec++;
    if (obs !== exp_vec()) begin n_err++; $display("FAIL ar_in_set_min: dut=%h model=%h", obs, exp_vec()); end
    @(negedge f100Hz);
    key_mode_n = 1'b0;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    n_vec++;
    if (obs !== exp_vec()) begin n_err++; $display("FAIL ar_immediate: dut=%h model=%h", obs, exp_vec()); end
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (300) @(negedge clk);
    n_vec++;
    if (obs !== exp_vec()) begin n_err++; $display("FAIL ar_key_held: dut=%h model=%h", obs, exp_vec()); end
    key_mode_n = 1'b1;
    repeat (60) @(negedge clk);
    n_vec++;
    if (obs !== exp_vec()) begin n_err++; $display("FAIL ar_key_released: dut=%h model=%h", obs, exp_vec()); end
    press_mode();
    n_vec++;
    if (obs !== exp_vec()) begin n_err++; $display("FAIL ar_repress: dut=%h model=%h", obs, exp_vec()); end
  endtask

  initial begin
    test_reset();
    test_set_sequence();
    test_collision();
    test_rollover();
    test_debounce();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
